// File: rtl/reg_list_sequencer_pkg.sv
// Shared types and constants for the PUSH/POP register-list sequencer.
package reg_list_sequencer_pkg;

  // Sequencer states: idle, issuing memory micro-ops, SP write-back.
  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_ISSUE  = 2'd1,
    SEQ_SP_UPD = 2'd2
  } seq_state_e;

  // Architectural register numbers used by the sequencer.
  localparam int unsigned SP_ADDR = 13;
  localparam int unsigned LR_ADDR = 14;
  localparam int unsigned PC_ADDR = 15;

  // Default datapath geometry.
  localparam int unsigned DEF_WORD       = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 4;
  localparam int unsigned DEF_LIST_WIDTH = 8;

endpackage : reg_list_sequencer_pkg

// File: rtl/reg_list_sequencer_if.sv
// Decode-stage <-> sequencer bundle. master = decoder side, slave = sequencer.
interface reg_list_sequencer_if
  import reg_list_sequencer_pkg::*;
#(
  parameter int unsigned WORD       = DEF_WORD,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LIST_WIDTH = DEF_LIST_WIDTH
);

  logic                  start_i;
  logic                  is_pop_i;
  logic [LIST_WIDTH-1:0] reg_list_i;
  logic                  extra_reg_i;
  logic                  flush_i;

  logic                  stall_o;
  logic                  busy_o;
  logic                  uop_valid_o;
  logic                  uop_is_load_o;
  logic [ADDR_WIDTH-1:0] uop_addr_o;
  logic [WORD-1:0]       uop_offset_o;
  logic                  uop_last_o;
  logic                  sp_update_o;
  logic [WORD-1:0]       sp_delta_o;

  modport master (
    output start_i, is_pop_i, reg_list_i, extra_reg_i, flush_i,
    input  stall_o, busy_o, uop_valid_o, uop_is_load_o, uop_addr_o,
           uop_offset_o, uop_last_o, sp_update_o, sp_delta_o
  );

  modport slave (
    input  start_i, is_pop_i, reg_list_i, extra_reg_i, flush_i,
    output stall_o, busy_o, uop_valid_o, uop_is_load_o, uop_addr_o,
           uop_offset_o, uop_last_o, sp_update_o, sp_delta_o
  );

endinterface : reg_list_sequencer_if

// File: rtl/reg_list_sequencer_lowest_bit_finder.sv
// Priority encoder: index and one-hot clear mask of the lowest set bit.
module lowest_bit_finder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] vec,
  output logic             found,
  output logic [IDX_W-1:0] idx,
  output logic [WIDTH-1:0] clr_mask
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    clr_mask = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found       = 1'b1;
        idx         = IDX_W'(i);
        clr_mask    = '0;
        clr_mask[i] = 1'b1;
      end
    end
  end

endmodule : lowest_bit_finder

// File: rtl/reg_list_sequencer.sv
// Expands a Thumb PUSH/POP register list into one memory micro-op per cycle
// followed by a single SP-update micro-op, stalling decode meanwhile.
// Optional feature macro: REG_LIST_LR_PC_EN (adds LR/PC as list bit LIST_WIDTH).
module reg_list_sequencer
  import reg_list_sequencer_pkg::*;
#(
  parameter int unsigned WORD       = DEF_WORD,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned LIST_WIDTH = DEF_LIST_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  reg_list_sequencer_if.slave  bus
);

`ifdef REG_LIST_LR_PC_EN
  localparam int unsigned EFF_W = LIST_WIDTH + 1;
`else
  localparam int unsigned EFF_W = LIST_WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(EFF_W + 1);
  localparam int unsigned IDX_W = (EFF_W > 1) ? $clog2(EFF_W) : 1;

  seq_state_e       state;
  logic [EFF_W-1:0] list_q;
  logic             is_pop_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;

  logic [EFF_W-1:0] eff_list;
  logic [CNT_W-1:0] eff_cnt;
  logic             accept;
  logic             fin_found;
  logic [IDX_W-1:0] fin_idx;
  logic [EFF_W-1:0] fin_mask;
  logic [EFF_W-1:0] list_rem;
  logic             is_last;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [WORD-1:0]  byte_total;
  logic [WORD-1:0]  byte_idx;

  // Effective list: optional LR/PC bit sits above the low registers.
`ifdef REG_LIST_LR_PC_EN
  assign eff_list = {bus.extra_reg_i, bus.reg_list_i};
`else
  logic unused_extra;
  assign unused_extra = bus.extra_reg_i;
  assign eff_list     = bus.reg_list_i;
`endif

  // Population count of the incoming list.
  always_comb begin
    eff_cnt = '0;
    for (int i = 0; i < int'(EFF_W); i++) begin
      eff_cnt = eff_cnt + CNT_W'(eff_list[i]);
    end
  end

  // Start is taken only from IDLE, never during flush/reset, never for an empty list.
  assign accept = (state == SEQ_IDLE) && bus.start_i && !bus.flush_i &&
                  !reset_i && (|eff_list);

  lowest_bit_finder #(
    .WIDTH (EFF_W),
    .IDX_W (IDX_W)
  ) u_finder (
    .vec      (list_q),
    .found    (fin_found),
    .idx      (fin_idx),
    .clr_mask (fin_mask)
  );

  assign list_rem = list_q & ~fin_mask;

  // Register number for the bit currently being issued.
  always_comb begin
    cur_addr = ADDR_WIDTH'(fin_idx);
`ifdef REG_LIST_LR_PC_EN
    if (fin_idx == IDX_W'(LIST_WIDTH)) begin
      cur_addr = is_pop_q ? ADDR_WIDTH'(PC_ADDR) : ADDR_WIDTH'(LR_ADDR);
    end
`endif
  end

  // A PC load always ends the memory phase.
`ifdef REG_LIST_LR_PC_EN
  assign is_last = (list_rem == '0) ||
                   (is_pop_q && (cur_addr == ADDR_WIDTH'(PC_ADDR)));
`else
  assign is_last = (list_rem == '0);
`endif

  assign byte_total = WORD'({cnt_q, 2'b00});
  assign byte_idx   = WORD'({idx_q, 2'b00});

  // Sequencing state: latch the list on accept, retire one bit per ISSUE cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= SEQ_IDLE;
      list_q   <= '0;
      is_pop_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else if (bus.flush_i) begin
      state    <= SEQ_IDLE;
      list_q   <= '0;
      is_pop_q <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
    end else begin
      case (state)
        SEQ_IDLE: begin
          if (accept) begin
            state    <= SEQ_ISSUE;
            list_q   <= eff_list;
            is_pop_q <= bus.is_pop_i;
            cnt_q    <= eff_cnt;
            idx_q    <= '0;
          end
        end
        SEQ_ISSUE: begin
          list_q <= list_rem;
          idx_q  <= idx_q + CNT_W'(1);
          if (is_last || !fin_found) begin
            state <= SEQ_SP_UPD;
          end
        end
        SEQ_SP_UPD: begin
          state    <= SEQ_IDLE;
          list_q   <= '0;
          is_pop_q <= 1'b0;
          cnt_q    <= '0;
          idx_q    <= '0;
        end
        default: begin
          state <= SEQ_IDLE;
        end
      endcase
    end
  end

  // Output decode; flush zeroes every valid and payload in the same cycle.
  always_comb begin
    bus.stall_o       = 1'b0;
    bus.busy_o        = (state != SEQ_IDLE);
    bus.uop_valid_o   = 1'b0;
    bus.uop_is_load_o = 1'b0;
    bus.uop_addr_o    = '0;
    bus.uop_offset_o  = '0;
    bus.uop_last_o    = 1'b0;
    bus.sp_update_o   = 1'b0;
    bus.sp_delta_o    = '0;
    case (state)
      SEQ_IDLE: begin
        bus.stall_o = accept;
      end
      SEQ_ISSUE: begin
        if (!bus.flush_i && fin_found) begin
          bus.stall_o       = 1'b1;
          bus.uop_valid_o   = 1'b1;
          bus.uop_is_load_o = is_pop_q;
          bus.uop_addr_o    = cur_addr;
          bus.uop_offset_o  = is_pop_q ? byte_idx : (byte_idx - byte_total);
          bus.uop_last_o    = is_last;
        end
      end
      SEQ_SP_UPD: begin
        if (!bus.flush_i) begin
          bus.sp_update_o = 1'b1;
          bus.sp_delta_o  = is_pop_q ? byte_total : (WORD'(0) - byte_total);
        end
      end
      default: begin
        bus.busy_o = 1'b1;
      end
    endcase
  end

endmodule : reg_list_sequencer

// File: tb/tb_reg_list_sequencer.sv
// Directed + randomized bench for reg_list_sequencer with a list-level reference model.
module tb_reg_list_sequencer;

  logic clk_i   = 1'b0;
  logic reset_i = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  reg_list_sequencer_if #(.WORD(32), .ADDR_WIDTH(4), .LIST_WIDTH(8)) bus ();

  reg_list_sequencer #(.WORD(32), .ADDR_WIDTH(4), .LIST_WIDTH(8)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Compare every output against one expected snapshot.
  task automatic check_outs(input string tag, input logic v, input logic ld,
                            input logic [31:0] addr, input logic [31:0] off,
                            input logic last, input logic spu,
                            input logic [31:0] delta, input logic stall);
    check({tag, ".valid"},  32'(bus.uop_valid_o),   32'(v));
    check({tag, ".load"},   32'(bus.uop_is_load_o), 32'(ld));
    check({tag, ".addr"},   32'(bus.uop_addr_o),    addr);
    check({tag, ".offset"}, bus.uop_offset_o,       off);
    check({tag, ".last"},   32'(bus.uop_last_o),    32'(last));
    check({tag, ".spu"},    32'(bus.sp_update_o),   32'(spu));
    check({tag, ".delta"},  bus.sp_delta_o,         delta);
    check({tag, ".stall"},  32'(bus.stall_o),       32'(stall));
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one instruction from IDLE. flush_k >= 0 flushes in that micro-op cycle.
  // Called just after a rising edge; returns just after a rising edge.
  task automatic run_instr(input string tag, input logic p, input logic [7:0] list,
                           input logic extra, input int flush_k);
    int regs[$];
    int n;
    logic [15:0] ev;
    int unsigned e_addr;
    logic [31:0] e_off;
    ev = {8'h00, list};
`ifdef REG_LIST_LR_PC_EN
    ev[8] = extra;
`endif
    // Registers touched, ascending; the stack image puts regs[k] at SP_start - 4n + 4k.
    for (int i = 0; i < 16; i++) if (ev[i]) regs.push_back(i);
    n = regs.size();

    bus.start_i     = 1'b1;
    bus.is_pop_i    = p;
    bus.reg_list_i  = list;
    bus.extra_reg_i = extra;
    @(negedge clk_i);
    check_outs({tag, ".idle"}, 0, 0, 0, 0, 0, 0, 0, (n != 0));
    check({tag, ".idle.busy"}, 32'(bus.busy_o), 0);

    if (n == 0) begin
      tick();
      bus.start_i = 1'b0;
      @(negedge clk_i);
      check_outs({tag, ".nop"}, 0, 0, 0, 0, 0, 0, 0, 0);
      check({tag, ".nop.busy"}, 32'(bus.busy_o), 0);
      tick();
      return;
    end

    for (int k = 0; k < n; k++) begin
      tick();
      // Held instruction keeps start high; its other fields wander to prove they were latched.
      bus.reg_list_i  = 8'($urandom);
      bus.is_pop_i    = 1'($urandom);
      bus.extra_reg_i = 1'($urandom);
      if (k == flush_k) bus.flush_i = 1'b1;
      @(negedge clk_i);
      if (k == flush_k) begin
        check_outs($sformatf("%s.flush%0d", tag, k), 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk_i);
        check_outs({tag, ".postflush"}, 0, 0, 0, 0, 0, 0, 0, 0);
        check({tag, ".postflush.busy"}, 32'(bus.busy_o), 0);
        tick();
        return;
      end
      e_addr = (regs[k] == 8) ? (p ? 15 : 14) : regs[k];
      e_off  = p ? 32'(4 * k) : 32'(4 * k - 4 * n);
      check_outs($sformatf("%s.uop%0d", tag, k), 1, p, e_addr, e_off, (k == n - 1), 0, 0, 1);
      check($sformatf("%s.uop%0d.busy", tag, k), 32'(bus.busy_o), 1);
    end

    tick();
    @(negedge clk_i);
    check_outs({tag, ".sp"}, 0, 0, 0, 0, 0, 1, p ? 32'(4 * n) : 32'(-4 * n), 0);
    check({tag, ".sp.busy"}, 32'(bus.busy_o), 1);

    tick();
    bus.start_i = 1'b0;
    @(negedge clk_i);
    check_outs({tag, ".done"}, 0, 0, 0, 0, 0, 0, 0, 0);
    check({tag, ".done.busy"}, 32'(bus.busy_o), 0);
    tick();
  endtask

  initial begin
    bus.start_i     = 1'b0;
    bus.is_pop_i    = 1'b0;
    bus.reg_list_i  = 8'h00;
    bus.extra_reg_i = 1'b0;
    bus.flush_i     = 1'b0;

    // Reset state.
    #12;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset.busy", 32'(bus.busy_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();

    // Directed cases.
    run_instr("push_r0r2r7", 1'b0, 8'h85, 1'b0, -1);
    run_instr("pop_r1",      1'b1, 8'h02, 1'b0, -1);
    run_instr("empty",       1'b0, 8'h00, 1'b0, -1);
    run_instr("push_r3r6_flush", 1'b0, 8'h78, 1'b0, 2);
    run_instr("pop_r0",      1'b1, 8'h01, 1'b0, -1);
    run_instr("push_all",    1'b0, 8'hFF, 1'b0, -1);
`ifdef REG_LIST_LR_PC_EN
    run_instr("push_r4_lr",  1'b0, 8'h10, 1'b1, -1);
    run_instr("pop_pc",      1'b1, 8'h00, 1'b1, -1);
`else
    run_instr("empty_extra", 1'b1, 8'h00, 1'b1, -1);
`endif

    // Flush while idle blocks a start.
    bus.start_i    = 1'b1;
    bus.reg_list_i = 8'h0F;
    bus.flush_i    = 1'b1;
    @(negedge clk_i);
    check_outs("idle_flush", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk_i);
    check("idle_flush.busy", 32'(bus.busy_o), 0);
    tick();

    // Asynchronous reset in the middle of ISSUE.
    bus.start_i    = 1'b1;
    bus.is_pop_i   = 1'b0;
    bus.reg_list_i = 8'hFF;
    tick();
    tick();
    #2;
    reset_i = 1'b1;
    #1;
    check_outs("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    check("async_rst.busy", 32'(bus.busy_o), 0);
    bus.start_i = 1'b0;
    tick();
    @(negedge clk_i);
    reset_i = 1'b0;
    tick();
    @(negedge clk_i);
    check_outs("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    check("post_rst.busy", 32'(bus.busy_o), 0);
    tick();
    run_instr("after_rst_pop", 1'b1, 8'h81, 1'b0, -1);

    // Randomized instructions.
    for (int t = 0; t < 40; t++) begin
      logic [7:0] rl;
      int fk;
      rl = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      fk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      run_instr($sformatf("rnd%0d", t), 1'($urandom), rl, 1'($urandom), fk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_reg_list_sequencer
